// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: PC register, imem req/ack fetch, decode handoff.
// Misaligned PC or memory timeout parks the unit in a sticky error state.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] nextPC,
    output logic [31:0] nowPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic advance;
    logic misaligned;
    logic timeout;

    assign advance    = (state_q == S_VALID) && instr_ready;
    assign misaligned = nextPC[1:0] != 2'b00;
    assign timeout    = (state_q == S_REQ) && !imem_ack && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (imem_ack) begin
                    state_d = S_VALID;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_VALID: begin
                if (instr_ready) begin
                    state_d = misaligned ? S_ERR : S_REQ;
                end
            end
            default: state_d = S_ERR;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            S_REQ:   imem_req    = 1'b1;
            S_VALID: instr_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers; the error flag is only ever set, reset clears it.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        code_d  = code_q;
        if (state_q == S_REQ) begin
            if (imem_ack) begin
                instr_d = imem_rdata;
                cnt_d   = '0;
            end else if (timeout) begin
                err_d  = 1'b1;
                code_d = 2'b10;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (advance) begin
            pc_d = nextPC;
            if (misaligned) begin
                err_d  = 1'b1;
                code_d = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign nowPC       = pc_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign fetch_err   = err_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, sequential fetch, stall, timeout,
// misaligned target and reset during fetch / error.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] nextPC;
    logic [31:0] nowPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;
    logic [1:0]  err_code;

    int n_cmp;
    int n_bad;

    ifu_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nextPC      (nextPC),
        .nowPC       (nowPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        instr_ready = 1'b0;
        nextPC = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (nowPC !== 32'h3000 || instr_valid !== 1'b0 || fetch_err !== 1'b0
            || err_code !== 2'b00 || instruction !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: got pc=%h v=%b e=%b c=%b i=%h want 3000 0 0 00 0",
                     nowPC, instr_valid, fetch_err, err_code, instruction);
        end
        rst_n = 1'b1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            n_bad++;
            $display("FAIL reset_req: got req=%b addr=%h want 1 3000", imem_req, imem_addr);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h3C01_0001;
        @(negedge clk);
        imem_ack = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b1 || instruction !== 32'h3C01_0001 || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL first_fetch: got v=%b i=%h req=%b want 1 3c010001 0",
                     instr_valid, instruction, imem_req);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] pc;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h3000 + 32'(4 * i);
            nextPC = pc + 32'd4;
            @(negedge clk);
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== pc + 32'd4 || instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL seq_req%0d: got req=%b addr=%h v=%b want 1 %h 0",
                         i, imem_req, imem_addr, instr_valid, pc + 32'd4);
            end
            imem_ack = 1'b1;
            imem_rdata = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            imem_ack = 1'b0;
            n_cmp++;
            if (instr_valid !== 1'b1 || instruction !== 32'hA000_0000 + 32'(i)
                || nowPC !== pc + 32'd4) begin
                n_bad++;
                $display("FAIL seq_data%0d: got v=%b i=%h pc=%h want 1 %h %h",
                         i, instr_valid, instruction, nowPC,
                         32'hA000_0000 + 32'(i), pc + 32'd4);
            end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall;
        nextPC = 32'h3040;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || nowPC !== 32'h3010
                || instruction !== 32'hA000_0003 || fetch_err !== 1'b0) begin
                n_bad++;
                $display("FAIL stall%0d: got v=%b req=%b pc=%h i=%h e=%b want 1 0 3010 a0000003 0",
                         i, instr_valid, imem_req, nowPC, instruction, fetch_err);
            end
        end
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3040) begin
            n_bad++;
            $display("FAIL stall_release: got req=%b addr=%h want 1 3040", imem_req, imem_addr);
        end
    endtask

    task automatic test_slow_mem;
        repeat (7) @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            n_bad++;
            $display("FAIL slow_wait: got req=%b e=%b want 1 0", imem_req, fetch_err);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b1 || instruction !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL slow_ack: got v=%b i=%h want 1 12345678", instr_valid, instruction);
        end
        nextPC = 32'h3044;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 15) begin
                n_cmp++;
                if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL timeout_early: got req=%b e=%b want 1 0", imem_req, fetch_err);
                end
            end
        end
        n_cmp++;
        if (fetch_err !== 1'b1 || err_code !== 2'b10 || imem_req !== 1'b0
            || instr_valid !== 1'b0 || nowPC !== 32'h3044) begin
            n_bad++;
            $display("FAIL timeout: got e=%b c=%b req=%b v=%b pc=%h want 1 10 0 0 3044",
                     fetch_err, err_code, imem_req, instr_valid, nowPC);
        end
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (nowPC !== 32'h3000 || fetch_err !== 1'b0 || err_code !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_from_err: got pc=%h e=%b c=%b want 3000 0 00",
                     nowPC, fetch_err, err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_1111;
        @(negedge clk);
        imem_ack = 1'b0;
        nextPC = 32'h3008;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin
            n_bad++;
            $display("FAIL mid_wait: got req=%b addr=%h want 1 3008", imem_req, imem_addr);
        end
        rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (nowPC !== 32'h3000 || imem_req !== 1'b1 || instr_valid !== 1'b0
            || instruction !== 32'h0 || fetch_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got pc=%h req=%b v=%b i=%h e=%b want 3000 1 0 0 0",
                     nowPC, imem_req, instr_valid, instruction, fetch_err);
        end
    endtask

    task automatic test_misaligned;
        imem_ack = 1'b1;
        imem_rdata = 32'h0800_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        nextPC = 32'h3002;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_cmp++;
        if (fetch_err !== 1'b1 || err_code !== 2'b01 || nowPC !== 32'h3002
            || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL misaligned: got e=%b c=%b pc=%h req=%b v=%b want 1 01 3002 0 0",
                     fetch_err, err_code, nowPC, imem_req, instr_valid);
        end
        imem_ack = 1'b1;
        instr_ready = 1'b1;
        nextPC = 32'h4000;
        imem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        n_cmp++;
        if (fetch_err !== 1'b1 || err_code !== 2'b01 || nowPC !== 32'h3002
            || instruction !== 32'h0800_0000 || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL err_sticky: got e=%b c=%b pc=%h i=%h req=%b want 1 01 3002 08000000 0",
                     fetch_err, err_code, nowPC, instruction, imem_req);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_slow_mem();
        test_reset_mid();
        test_misaligned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
